fetch_buffer: RTL

- Decoupling queue between the fetch stage and decode.
- Captures each completed fetch (PC, instruction word, ID, fault metadata) into a circular buffer and presents it to decode through a valid/ready handshake.
- Fetch cannot stall returning memory data, so the block reserves one slot per issued request. It only permits a new request when a slot is guaranteed.
- Flushes discard buffered entries. Reservations held by in-flight requests are kept until those requests resolve.

---
 rtl/fetch_buffer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fetch_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_buffer                                                  |
// | Brief    : Fetch-to-decode decoupling queue with per-request slot        |
// |            reservation. Optional same-cycle bypass when empty, enabled   |
// |            by defining FETCH_BUFFER_BYPASS_EN.                           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 3,
  parameter int ERR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     req_issue,
  output logic                     issue_allowed,
  input  logic                     push,
  input  logic                     drop,
  input  logic [31:0]              push_pc,
  input  logic [31:0]              push_instruction,
  input  logic [ID_W-1:0]          push_id,
  input  logic                     push_ok,
  input  logic [ERR_W-1:0]         push_error_code,
  output logic                     decode_valid,
  input  logic                     decode_ready,
  output logic [31:0]              decode_pc,
  output logic [31:0]              decode_instruction,
  output logic [ID_W-1:0]          decode_id,
  output logic                     decode_ok,
  output logic [ERR_W-1:0]         decode_error_code,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int c_IDX_W = $clog2(DEPTH);
  localparam int c_PTR_W = c_IDX_W + 1;

  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_count;
  logic [c_PTR_W-1:0] r_reserved;

  logic [31:0]       r_pc_mem  [DEPTH];
  logic [31:0]       r_ins_mem [DEPTH];
  logic [ID_W-1:0]   r_id_mem  [DEPTH];
  logic              r_ok_mem  [DEPTH];
  logic [ERR_W-1:0]  r_err_mem [DEPTH];

  logic               w_empty;
  logic               w_full;
  logic               w_bypass;
  logic               w_pop_buf;
  logic               w_wr_en;
  logic [c_PTR_W:0]   w_budget;
  logic [c_IDX_W-1:0] w_rd_idx;
  logic [c_IDX_W-1:0] w_wr_idx;

  assign w_rd_idx = r_rd_ptr[c_IDX_W-1:0];
  assign w_wr_idx = r_wr_ptr[c_IDX_W-1:0];
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[c_IDX_W] != r_rd_ptr[c_IDX_W]) &&
                    (r_wr_ptr[c_IDX_W-1:0] == r_rd_ptr[c_IDX_W-1:0]);

`ifdef FETCH_BUFFER_BYPASS_EN
  assign w_bypass = w_empty & push & ~flush;
`else
  assign w_bypass = 1'b0;
`endif

  // Budget uses registered state only, so a same-cycle push/pop never loops back.
  assign w_budget      = {1'b0, r_count} + {1'b0, r_reserved};
  assign issue_allowed = (w_budget < (c_PTR_W+1)'(DEPTH));

  assign decode_valid = ~w_empty | w_bypass;
  assign w_pop_buf    = ~w_empty & decode_ready & ~flush;
  // A bypassed entry taken by decode never lands in the array.
  assign w_wr_en      = push & ~flush & ~(w_bypass & decode_ready);
  assign occupancy    = r_count;

  assign decode_pc          = w_bypass ? push_pc          : r_pc_mem[w_rd_idx];
  assign decode_instruction = w_bypass ? push_instruction : r_ins_mem[w_rd_idx];
  assign decode_id          = w_bypass ? push_id          : r_id_mem[w_rd_idx];
  assign decode_ok          = w_bypass ? push_ok          : r_ok_mem[w_rd_idx];
  assign decode_error_code  = w_bypass ? push_error_code  : r_err_mem[w_rd_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_reserved <= '0;
    end else begin
      // Reservations survive flush: in-flight requests still resolve later.
      r_reserved <= r_reserved + c_PTR_W'(req_issue) - c_PTR_W'(push) - c_PTR_W'(drop);
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_wr_en) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        if (w_pop_buf) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        r_count <= r_count + c_PTR_W'(w_wr_en) - c_PTR_W'(w_pop_buf);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]  <= '0;
        r_ins_mem[i] <= '0;
        r_id_mem[i]  <= '0;
        r_ok_mem[i]  <= 1'b0;
        r_err_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_pc_mem[w_wr_idx]  <= push_pc;
      r_ins_mem[w_wr_idx] <= push_instruction;
      r_id_mem[w_wr_idx]  <= push_id;
      r_ok_mem[w_wr_idx]  <= push_ok;
      r_err_mem[w_wr_idx] <= push_error_code;
    end
  end

  a_resolve_needs_resv: assert property (@(posedge clk) disable iff (!rst)
    (push | drop) |-> (r_reserved != '0))
    else $error("fetch_buffer: push/drop with no outstanding reservation");

  a_push_drop_excl: assert property (@(posedge clk) disable iff (!rst)
    !(push && drop))
    else $error("fetch_buffer: push and drop in the same cycle");

  a_issue_allowed: assert property (@(posedge clk) disable iff (!rst)
    req_issue |-> issue_allowed)
    else $error("fetch_buffer: req_issue while issue not allowed");

  a_push_full: assert property (@(posedge clk) disable iff (!rst)
    !(push && w_full))
    else $error("fetch_buffer: push while full");

endmodule
`default_nettype wire
